// File: rtl/lsu_seq.sv
// rtl/lsu_seq.sv - load/store sequencer: bus alignment, byte strobes, split beats, load extension
module lsu_seq #(
   parameter int XLEN     = 32,
   parameter int ADDR_W   = 32,
   parameter int SPLIT_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              halt_req,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic [1:0]        req_type,
   input  logic              req_sign,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_wstrb,
   output logic              mem_rmem,
   output logic              mem_wmem,
   input  logic              mem_busy,
   input  logic [XLEN-1:0]   mem_rdata
);
   localparam int NB    = XLEN/8;
   localparam int OFS_W = $clog2(NB);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ0, S_CAP0, S_REQ1, S_CAP1, S_RESP
   } state_t;

   state_t state, state_nx;

   logic              we_r, sign_r, err_r;
   logic [1:0]        type_r;
   logic [ADDR_W-1:0] addr_r;
   logic [XLEN-1:0]   wdata_r, lo_r, hi_r;

   // One past the last byte touched, relative to the bus word start
   function automatic logic [4:0] span_end(input logic [OFS_W-1:0] ofs, input logic [1:0] t);
      return 5'(ofs) + (5'd1 << t);
   endfunction

   logic              accept;
   logic              in_bad_type, in_cross, in_err;
   logic [OFS_W-1:0]  ofs_r;
   logic              cross_r;
   logic [3:0]        size_b;
   logic [NB-1:0]     size_mask;
   logic [2*NB-1:0]   strb_full;
   logic [2*XLEN-1:0] wdata_full;
   logic [ADDR_W-1:0] aligned;
   logic [XLEN-1:0]   ld_shift, ld_mask, ld_ext;
   logic              ld_sbit;

   assign accept      = req_valid && req_ready;
   assign in_bad_type = (5'd1 << req_type) > 5'(NB);
   assign in_cross    = span_end(req_addr[OFS_W-1:0], req_type) > 5'(NB);
   assign in_err      = in_bad_type || (in_cross && SPLIT_EN == 0);

   assign ofs_r      = addr_r[OFS_W-1:0];
   assign cross_r    = span_end(ofs_r, type_r) > 5'(NB);
   assign size_b     = 4'd1 << type_r;
   assign size_mask  = ~({NB{1'b1}} << size_b);
   // Upper halves of these double-width shifts are exactly the second-beat values
   assign strb_full  = {{NB{1'b0}}, size_mask} << ofs_r;
   assign wdata_full = {{XLEN{1'b0}}, wdata_r} << {ofs_r, 3'b000};
   assign aligned    = {addr_r[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};

   assign ld_shift = XLEN'({hi_r, lo_r} >> {ofs_r, 3'b000});
   assign ld_mask  = ~({XLEN{1'b1}} << {size_b, 3'b000});
   assign ld_sbit  = |(ld_shift & (ld_mask ^ (ld_mask >> 1)));
   assign ld_ext   = (sign_r && ld_sbit) ? (ld_shift | ~ld_mask) : (ld_shift & ld_mask);

   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      mem_rmem  = 1'b0;
      mem_wmem  = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = !halt_req && !rst;
            if (accept)
               state_nx = in_err ? S_RESP : S_REQ0;
         end
         S_REQ0: begin
            mem_addr  = aligned;
            mem_wdata = wdata_full[XLEN-1:0];
            mem_wstrb = strb_full[NB-1:0];
            mem_rmem  = !we_r;
            mem_wmem  = we_r;
            if (!mem_busy)
               state_nx = S_CAP0;
         end
         S_CAP0:  state_nx = cross_r ? S_REQ1 : S_RESP;
         S_REQ1: begin
            mem_addr  = aligned + ADDR_W'(NB);
            mem_wdata = wdata_full[2*XLEN-1:XLEN];
            mem_wstrb = strb_full[2*NB-1:NB];
            mem_rmem  = !we_r;
            mem_wmem  = we_r;
            if (!mem_busy)
               state_nx = S_CAP1;
         end
         S_CAP1:  state_nx = S_RESP;
         S_RESP:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         we_r       <= 1'b0;
         sign_r     <= 1'b0;
         err_r      <= 1'b0;
         type_r     <= '0;
         addr_r     <= '0;
         wdata_r    <= '0;
         lo_r       <= '0;
         hi_r       <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         state      <= state_nx;
         resp_valid <= (state == S_RESP);
         resp_err   <= (state == S_RESP) && err_r;
         resp_rdata <= (state == S_RESP && !err_r && !we_r) ? ld_ext : '0;
         if (accept) begin
            we_r    <= req_we;
            sign_r  <= req_sign;
            err_r   <= in_err;
            type_r  <= req_type;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            hi_r    <= '0;
         end
         if (state == S_CAP0)
            lo_r <= mem_rdata;
         if (state == S_CAP1)
            hi_r <= mem_rdata;
      end
   end
endmodule

// File: tb/tb_lsu_seq.sv
// tb/tb_lsu_seq.sv - directed vector bench for lsu_seq with a small bus memory model
module tb_lsu_seq;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, halt_req, req_valid, req_ready, req_we, req_sign;
   logic        resp_valid, resp_err, mem_rmem, mem_wmem, mem_busy;
   logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  req_type;
   logic [3:0]  mem_wstrb;

   logic        n_req_valid, n_req_ready, n_resp_valid, n_resp_err, n_mem_rmem, n_mem_wmem;
   logic [31:0] n_req_addr, n_resp_rdata, n_mem_addr, n_mem_wdata;
   logic [1:0]  n_req_type;
   logic [3:0]  n_mem_wstrb;
   logic [31:0] n_mem_rdata = 32'hA5A5_5A5A;
   logic        n_mem_busy  = 1'b0;
   logic        n_cmd_seen  = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   lsu_seq #(.XLEN(32), .ADDR_W(32), .SPLIT_EN(1)) dut (
      .clk(clk), .rst(rst), .halt_req(halt_req),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_type(req_type), .req_sign(req_sign),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rmem(mem_rmem), .mem_wmem(mem_wmem), .mem_busy(mem_busy), .mem_rdata(mem_rdata)
   );

   lsu_seq #(.XLEN(32), .ADDR_W(32), .SPLIT_EN(0)) dut_ns (
      .clk(clk), .rst(rst), .halt_req(1'b0),
      .req_valid(n_req_valid), .req_ready(n_req_ready), .req_we(1'b0),
      .req_addr(n_req_addr), .req_wdata(32'h0), .req_type(n_req_type), .req_sign(1'b0),
      .resp_valid(n_resp_valid), .resp_rdata(n_resp_rdata), .resp_err(n_resp_err),
      .mem_addr(n_mem_addr), .mem_wdata(n_mem_wdata), .mem_wstrb(n_mem_wstrb),
      .mem_rmem(n_mem_rmem), .mem_wmem(n_mem_wmem), .mem_busy(n_mem_busy), .mem_rdata(n_mem_rdata)
   );

   always @(posedge clk)
      if (n_mem_rmem || n_mem_wmem) n_cmd_seen <= 1'b1;

   // Bus memory: accepts a command when not busy, returns read data the next cycle
   logic [31:0] mem [256];
   logic [31:0] rd_q;
   logic        pl_go;
   logic [7:0]  pl_i0, pl_i1;
   logic [31:0] pl_w0, pl_w1;
   logic [31:0] lg_addr [16];
   logic [31:0] lg_wdata [16];
   logic [3:0]  lg_strb [16];
   int          beat_total = 0;

   always @(posedge clk) begin
      if (pl_go) begin
         mem[pl_i0] <= pl_w0;
         mem[pl_i1] <= pl_w1;
      end
      if (!rst && (mem_rmem || mem_wmem) && !mem_busy) begin
         rd_q <= mem[mem_addr[9:2]];
         if (mem_wmem)
            for (int b = 0; b < 4; b++)
               if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
         lg_addr[beat_total[3:0]]  <= mem_addr;
         lg_wdata[beat_total[3:0]] <= mem_wdata;
         lg_strb[beat_total[3:0]]  <= mem_wstrb;
         beat_total <= beat_total + 1;
      end
   end
   assign mem_rdata = rd_q;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] w0, input logic [31:0] w1);
      @(negedge clk);
      pl_i0 = addr[9:2];
      pl_i1 = addr[9:2] + 8'd1;
      pl_w0 = w0;
      pl_w1 = w1;
      pl_go = 1'b1;
      @(negedge clk);
      pl_go = 1'b0;
   endtask

   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] typ, input logic sgn, input int busy_n, input logic halt_k0,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int first, output int nbeats);
      int w;
      w = 0;
      @(negedge clk);
      while (!req_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      first     = beat_total;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_type  = typ;
      req_sign  = sgn;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      if (busy_n > 0) mem_busy = 1'b1;
      if (halt_k0) halt_req = 1'b1;
      lat = -1;
      rdata = 32'h0;
      err = 1'b0;
      for (int k = 1; k <= 40 && lat < 0; k++) begin
         @(negedge clk);
         if (busy_n > 0 && k <= busy_n) begin
            chk($sformatf("busy_addr_k%0d", k), mem_addr, addr & 32'hFFFF_FFFC);
            chk($sformatf("busy_rmem_k%0d", k), {31'b0, mem_rmem}, 32'd1);
            chk($sformatf("busy_strb_k%0d", k), {28'b0, mem_wstrb}, 32'hF);
            if (k == busy_n) mem_busy = 1'b0;
         end
         if (resp_valid) begin
            lat = k;
            rdata = resp_rdata;
            err = resp_err;
         end
      end
      nbeats = beat_total - first;
   endtask

   task automatic n_req(input logic [31:0] addr, input logic [1:0] typ,
                        output int lat, output logic [31:0] rdata, output logic err);
      int w;
      w = 0;
      @(negedge clk);
      while (!n_req_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      n_req_valid = 1'b1;
      n_req_addr  = addr;
      n_req_type  = typ;
      @(posedge clk);
      @(negedge clk);
      n_req_valid = 1'b0;
      lat = -1;
      rdata = 32'h0;
      err = 1'b0;
      for (int k = 1; k <= 40 && lat < 0; k++) begin
         @(negedge clk);
         if (n_resp_valid) begin
            lat = k;
            rdata = n_resp_rdata;
            err = n_resp_err;
         end
      end
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr, wdata;
      logic [1:0]  typ;
      logic        sgn;
      logic [31:0] w0, w1, rdata;
      logic        err;
      int          lat, nb;
      logic [31:0] a0;
      logic [3:0]  s0;
      logic [31:0] d0, a1;
      logic [3:0]  s1;
      logic [31:0] d1;
   } vec_t;

   vec_t vt [14];

   initial begin
      int          lat, first, nb, cnt;
      logic [31:0] rd;
      logic        er;

      vt[0]  = '{1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 32'h8000_1234, 32'h0, 32'h8000_1234, 1'b0, 3, 1, 32'h100, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0};
      vt[1]  = '{1'b0, 32'h103, 32'h0, 2'd0, 1'b1, 32'h80AA_BBCC, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 1, 32'h100, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0};
      vt[2]  = '{1'b0, 32'h103, 32'h0, 2'd0, 1'b0, 32'h80AA_BBCC, 32'h0, 32'h0000_0080, 1'b0, 3, 1, 32'h100, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0};
      vt[3]  = '{1'b0, 32'h101, 32'h0, 2'd1, 1'b1, 32'h80AA_BBCC, 32'h0, 32'hFFFF_AABB, 1'b0, 3, 1, 32'h100, 4'h6, 32'h0, 32'h0, 4'h0, 32'h0};
      vt[4]  = '{1'b0, 32'h102, 32'h0, 2'd1, 1'b0, 32'h80AA_BBCC, 32'h0, 32'h0000_80AA, 1'b0, 3, 1, 32'h100, 4'hC, 32'h0, 32'h0, 4'h0, 32'h0};
      vt[5]  = '{1'b0, 32'h0FE, 32'h0, 2'd2, 1'b0, 32'h1122_3344, 32'h5566_7788, 32'h7788_1122, 1'b0, 5, 2, 32'h0FC, 4'hC, 32'h0, 32'h100, 4'h3, 32'h0};
      vt[6]  = '{1'b0, 32'h0FF, 32'h0, 2'd1, 1'b1, 32'h1122_3344, 32'h5566_7788, 32'hFFFF_8811, 1'b0, 5, 2, 32'h0FC, 4'h8, 32'h0, 32'h100, 4'h1, 32'h0};
      vt[7]  = '{1'b0, 32'h100, 32'h0, 2'd0, 1'b1, 32'h0000_007F, 32'h0, 32'h0000_007F, 1'b0, 3, 1, 32'h100, 4'h1, 32'h0, 32'h0, 4'h0, 32'h0};
      vt[8]  = '{1'b1, 32'h0FE, 32'hDDCC_BBAA, 2'd2, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5, 2, 32'h0FC, 4'hC, 32'hBBAA_0000, 32'h100, 4'h3, 32'h0000_DDCC};
      vt[9]  = '{1'b1, 32'h101, 32'h0000_00EE, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 3, 1, 32'h100, 4'h2, 32'h0000_EE00, 32'h0, 4'h0, 32'h0};
      vt[10] = '{1'b0, 32'h100, 32'h0, 2'd3, 1'b0, 32'h1234_5678, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
      vt[11] = '{1'b0, 32'hFFFF_FFFE, 32'h0, 2'd2, 1'b0, 32'hCAFE_BABE, 32'h0123_4567, 32'h4567_CAFE, 1'b0, 5, 2, 32'hFFFF_FFFC, 4'hC, 32'h0, 32'h0, 4'h3, 32'h0};
      vt[12] = '{1'b1, 32'h0FF, 32'hFFFF_9876, 2'd1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5, 2, 32'h0FC, 4'h8, 32'h7600_0000, 32'h100, 4'h1, 32'h00FF_FF98};
      vt[13] = '{1'b1, 32'h104, 32'h1234_5678, 2'd2, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 3, 1, 32'h104, 4'hF, 32'h1234_5678, 32'h0, 4'h0, 32'h0};

      rst = 1'b1; halt_req = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_sign = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0; req_type = 2'd0; mem_busy = 1'b0;
      pl_go = 1'b0; pl_i0 = 8'h0; pl_i1 = 8'h0; pl_w0 = 32'h0; pl_w1 = 32'h0;
      n_req_valid = 1'b0; n_req_addr = 32'h0; n_req_type = 2'd0;

      repeat (3) @(negedge clk);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_cmds", {30'b0, mem_rmem, mem_wmem}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         preload(vt[i].addr, vt[i].w0, vt[i].w1);
         do_req(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].typ, vt[i].sgn, 0, 1'b0, lat, rd, er, first, nb);
         chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
         chk($sformatf("v%0d_rdata", i), rd, vt[i].rdata);
         chk($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, vt[i].err});
         chk($sformatf("v%0d_beats", i), 32'(nb), 32'(vt[i].nb));
         if (nb >= 1 && vt[i].nb >= 1) begin
            chk($sformatf("v%0d_addr0", i), lg_addr[first % 16], vt[i].a0);
            chk($sformatf("v%0d_strb0", i), {28'b0, lg_strb[first % 16]}, {28'b0, vt[i].s0});
            if (vt[i].we) chk($sformatf("v%0d_wdata0", i), lg_wdata[first % 16], vt[i].d0);
         end
         if (nb == 2 && vt[i].nb == 2) begin
            chk($sformatf("v%0d_addr1", i), lg_addr[(first + 1) % 16], vt[i].a1);
            chk($sformatf("v%0d_strb1", i), {28'b0, lg_strb[(first + 1) % 16]}, {28'b0, vt[i].s1});
            if (vt[i].we) chk($sformatf("v%0d_wdata1", i), lg_wdata[(first + 1) % 16], vt[i].d1);
         end
      end

      // Three busy cycles in REQ0 stretch a single-beat load from 3 to 6 cycles
      preload(32'h100, 32'h0BAD_F00D, 32'h0);
      do_req(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 3, 1'b0, lat, rd, er, first, nb);
      chk("busy_lat", 32'(lat), 32'd6);
      chk("busy_rdata", rd, 32'h0BAD_F00D);
      chk("busy_beats", 32'(nb), 32'd1);

      // Halt raised mid-access: access completes, then no new request is taken
      preload(32'h100, 32'h1357_9BDF, 32'h0);
      do_req(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 0, 1'b1, lat, rd, er, first, nb);
      chk("halt_lat", 32'(lat), 32'd3);
      chk("halt_rdata", rd, 32'h1357_9BDF);
      req_valid = 1'b1;
      cnt = beat_total;
      repeat (3) begin
         @(negedge clk);
         chk("halt_ready_low", {31'b0, req_ready}, 32'd0);
      end
      chk("halt_no_beat", 32'(beat_total - cnt), 32'd0);
      req_valid = 1'b0;
      halt_req = 1'b0;
      #1;
      chk("halt_ready_back", {31'b0, req_ready}, 32'd1);

      // Reset while in CAP0 abandons the access with no response
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_type = 2'd2;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_cmds", {30'b0, mem_rmem, mem_wmem}, 32'd0);
      chk("rstmid_addr", mem_addr, 32'd0);
      chk("rstmid_strb", {28'b0, mem_wstrb}, 32'd0);
      chk("rstmid_wdata", mem_wdata, 32'd0);
      chk("rstmid_resp_valid", {31'b0, resp_valid}, 32'd0);
      rst = 1'b0;
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (resp_valid) cnt++;
      end
      chk("rstmid_no_resp", 32'(cnt), 32'd0);
      chk("rstmid_ready", {31'b0, req_ready}, 32'd1);

      // SPLIT_EN=0 instance: crossing and oversize requests error without a bus command
      n_req(32'h003, 2'd1, lat, rd, er);
      chk("ns_cross_lat", 32'(lat), 32'd1);
      chk("ns_cross_err", {31'b0, er}, 32'd1);
      chk("ns_cross_rdata", rd, 32'd0);
      n_req(32'h000, 2'd3, lat, rd, er);
      chk("ns_dword_lat", 32'(lat), 32'd1);
      chk("ns_dword_err", {31'b0, er}, 32'd1);
      chk("ns_no_cmd", {31'b0, n_cmd_seen}, 32'd0);
      n_req(32'h001, 2'd1, lat, rd, er);
      chk("ns_mis_lat", 32'(lat), 32'd3);
      chk("ns_mis_err", {31'b0, er}, 32'd0);
      chk("ns_mis_rdata", rd, 32'h0000_A55A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
